// File: rtl/control_unit.sv
// Main decoder for the single-cycle RV32I-subset core: instruction decode,
// branch resolution from ALU flags, and a sticky EBREAK halt flag.
module control_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] im_data,
  input  logic        ALUzero,
  input  logic        ALUneg,
  output logic        RegWrite,
  output logic        ALUsrc,
  output logic [1:0]  PCsrc,
  output logic [1:0]  MemWrite,
  output logic [2:0]  ALUctl,
  output logic [2:0]  MemtoReg,
  output logic        halt
);

  localparam int unsigned OPC_W = 7;
  localparam int unsigned F3_W  = 3;

  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [24:0] EBREAK_HI = 25'h0002000;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_PASS = 3'b110;

  localparam logic [2:0] WB_ALU   = 3'b000;
  localparam logic [2:0] WB_WORD  = 3'b001;
  localparam logic [2:0] WB_HALF  = 3'b010;
  localparam logic [2:0] WB_BYTE  = 3'b011;
  localparam logic [2:0] WB_PC4   = 3'b100;
  localparam logic [2:0] WB_PCIMM = 3'b101;

  localparam logic [1:0] PC_NEXT = 2'b00;
  localparam logic [1:0] PC_REL  = 2'b01;
  localparam logic [1:0] PC_JALR = 2'b10;
  localparam logic [1:0] PC_HOLD = 2'b11;

  localparam logic [1:0] MW_NONE = 2'b00;
  localparam logic [1:0] MW_BYTE = 2'b01;
  localparam logic [1:0] MW_HALF = 2'b10;
  localparam logic [1:0] MW_WORD = 2'b11;

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

  state_t state, state_n;

  logic [OPC_W-1:0] opcode;
  logic [F3_W-1:0]  funct3;
  logic             bit30;
  logic             is_ebreak;
  logic             taken;

  assign opcode    = im_data[6:0];
  assign funct3    = im_data[14:12];
  assign bit30     = im_data[30];
  assign is_ebreak = (opcode == OPC_SYSTEM) && (im_data[31:7] == EBREAK_HI);
  assign halt      = (state == ST_HALTED);

  // Halt state register; reset clears it asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RUN;
    else       state <= state_n;
  end

  // Branch condition from ALU flags of rs1 - rs2.
  always_comb begin
    taken = 1'b0;
    unique case (funct3)
      3'b000:  taken = ALUzero;
      3'b001:  taken = ~ALUzero;
      3'b100:  taken = ALUneg;
      3'b101:  taken = ~ALUneg;
      default: taken = 1'b0;
    endcase
  end

  // Next halt state and instruction decode.
  always_comb begin
    state_n  = state;
    RegWrite = 1'b0;
    ALUsrc   = 1'b0;
    PCsrc    = PC_NEXT;
    MemWrite = MW_NONE;
    ALUctl   = ALU_ADD;
    MemtoReg = WB_ALU;

    if (state == ST_RUN && is_ebreak) state_n = ST_HALTED;

    unique case (opcode)
      OPC_OP: begin
        unique case (funct3)
          3'b000:  begin RegWrite = 1'b1; ALUctl = bit30 ? ALU_SUB : ALU_ADD; end
          3'b111:  begin RegWrite = 1'b1; ALUctl = ALU_AND; end
          3'b110:  begin RegWrite = 1'b1; ALUctl = ALU_OR;  end
          3'b100:  begin RegWrite = 1'b1; ALUctl = ALU_XOR; end
          3'b001:  begin RegWrite = 1'b1; ALUctl = ALU_SLL; end
          default: ;
        endcase
      end
      OPC_OP_IMM: begin
        unique case (funct3)
          3'b000:  begin RegWrite = 1'b1; ALUsrc = 1'b1; ALUctl = ALU_ADD; end
          3'b111:  begin RegWrite = 1'b1; ALUsrc = 1'b1; ALUctl = ALU_AND; end
          3'b110:  begin RegWrite = 1'b1; ALUsrc = 1'b1; ALUctl = ALU_OR;  end
          3'b100:  begin RegWrite = 1'b1; ALUsrc = 1'b1; ALUctl = ALU_XOR; end
          3'b001:  begin RegWrite = 1'b1; ALUsrc = 1'b1; ALUctl = ALU_SLL; end
          default: ;
        endcase
      end
      OPC_LOAD: begin
        RegWrite = 1'b1;
        ALUsrc   = 1'b1;
        unique case (funct3)
          3'b001:  MemtoReg = WB_HALF;
          3'b000:  MemtoReg = WB_BYTE;
          default: MemtoReg = WB_WORD;
        endcase
      end
      OPC_STORE: begin
        ALUsrc = 1'b1;
        unique case (funct3)
          3'b000:  MemWrite = MW_BYTE;
          3'b001:  MemWrite = MW_HALF;
          3'b010:  MemWrite = MW_WORD;
          default: MemWrite = MW_NONE;
        endcase
      end
      OPC_BRANCH: begin
        ALUctl = ALU_SUB;
        PCsrc  = taken ? PC_REL : PC_NEXT;
      end
      OPC_LUI: begin
        RegWrite = 1'b1;
        ALUsrc   = 1'b1;
        ALUctl   = ALU_PASS;
      end
      OPC_AUIPC: begin
        RegWrite = 1'b1;
        MemtoReg = WB_PCIMM;
      end
      OPC_JAL: begin
        RegWrite = 1'b1;
        PCsrc    = PC_REL;
        MemtoReg = WB_PC4;
      end
      OPC_JALR: begin
        RegWrite = 1'b1;
        ALUsrc   = 1'b1;
        PCsrc    = PC_JALR;
        MemtoReg = WB_PC4;
      end
      OPC_SYSTEM: begin
        if (is_ebreak) PCsrc = PC_HOLD;
      end
      default: ;
    endcase

    // A halted core keeps decoding but must not commit state or advance.
    if (state == ST_HALTED) begin
      RegWrite = 1'b0;
      MemWrite = MW_NONE;
      PCsrc    = PC_HOLD;
    end

    if (reset) begin
      state_n  = ST_RUN;
      RegWrite = 1'b0;
      ALUsrc   = 1'b0;
      PCsrc    = PC_NEXT;
      MemWrite = MW_NONE;
      ALUctl   = ALU_ADD;
      MemtoReg = WB_ALU;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expected decode pushed to a scoreboard
// queue at each stimulus step, popped and compared once outputs settle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] im_data = 32'h0;
  logic        ALUzero = 1'b0;
  logic        ALUneg = 1'b0;
  logic        RegWrite, ALUsrc, halt;
  logic [1:0]  PCsrc, MemWrite;
  logic [2:0]  ALUctl, MemtoReg;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [11:0] outs;
    logic        hlt;
  } exp_t;

  exp_t sb[$];

  control_unit dut (
    .clk(clk), .reset(reset), .im_data(im_data), .ALUzero(ALUzero), .ALUneg(ALUneg),
    .RegWrite(RegWrite), .ALUsrc(ALUsrc), .PCsrc(PCsrc), .MemWrite(MemWrite),
    .ALUctl(ALUctl), .MemtoReg(MemtoReg), .halt(halt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // outs = {RegWrite, ALUsrc, PCsrc[1:0], MemWrite[1:0], ALUctl[2:0], MemtoReg[2:0]}
  task automatic step(input string tag, input logic [31:0] im, input logic z, input logic n,
                      input logic [11:0] e, input logic eh);
    exp_t x;
    logic [11:0] obs;
    im_data = im;
    ALUzero = z;
    ALUneg  = n;
    sb.push_back('{tag, e, eh});
    #1;
    x = sb.pop_front();
    obs = {RegWrite, ALUsrc, PCsrc, MemWrite, ALUctl, MemtoReg};
    checks++;
    assert (obs === x.outs) else begin
      failures++;
      $error("FAIL %s outputs: observed=%b required=%b", x.tag, obs, x.outs);
    end
    checks++;
    assert (halt === x.hlt) else begin
      failures++;
      $error("FAIL %s halt: observed=%b required=%b", x.tag, halt, x.hlt);
    end
  endtask

  initial begin
    // Reset forces NOP outputs and blocks EBREAK from setting halt.
    step("reset_sub_nop",  32'h40000033, 1'b0, 1'b0, 12'b0_0_00_00_000_000, 1'b0);
    step("reset_ebreak",   32'h00100073, 1'b0, 1'b0, 12'b0_0_00_00_000_000, 1'b0);
    @(posedge clk); #1;
    step("reset_no_halt",  32'h00100073, 1'b0, 1'b0, 12'b0_0_00_00_000_000, 1'b0);
    @(negedge clk);
    im_data = 32'h0;
    reset = 1'b0;

    @(negedge clk);
    step("sub",     32'h40000033, 1'b0, 1'b0, 12'b1_0_00_00_001_000, 1'b0);
    step("add",     32'h00000033, 1'b0, 1'b0, 12'b1_0_00_00_000_000, 1'b0);
    step("or",      32'h00006033, 1'b0, 1'b0, 12'b1_0_00_00_011_000, 1'b0);
    step("xor",     32'h00004033, 1'b0, 1'b0, 12'b1_0_00_00_100_000, 1'b0);
    step("sll",     32'h00001033, 1'b0, 1'b0, 12'b1_0_00_00_101_000, 1'b0);
    step("slt_nop", 32'h00002033, 1'b1, 1'b1, 12'b0_0_00_00_000_000, 1'b0);
    step("andi",    32'h00007013, 1'b0, 1'b0, 12'b1_1_00_00_010_000, 1'b0);
    step("addi_b30",32'h40000013, 1'b0, 1'b0, 12'b1_1_00_00_000_000, 1'b0);
    step("lh",      32'h00001003, 1'b0, 1'b0, 12'b1_1_00_00_000_010, 1'b0);
    step("lb",      32'h00000003, 1'b0, 1'b0, 12'b1_1_00_00_000_011, 1'b0);
    step("lw",      32'h00002003, 1'b0, 1'b0, 12'b1_1_00_00_000_001, 1'b0);
    step("ld_word", 32'h00003003, 1'b0, 1'b0, 12'b1_1_00_00_000_001, 1'b0);
    step("sw",      32'h00002023, 1'b0, 1'b0, 12'b0_1_00_11_000_000, 1'b0);
    step("sb",      32'h00000023, 1'b0, 1'b0, 12'b0_1_00_01_000_000, 1'b0);
    step("sh",      32'h00001023, 1'b0, 1'b0, 12'b0_1_00_10_000_000, 1'b0);
    step("st_bad",  32'h00003023, 1'b0, 1'b0, 12'b0_1_00_00_000_000, 1'b0);

    @(negedge clk);
    step("bne_z1",  32'h00001063, 1'b1, 1'b0, 12'b0_0_00_00_001_000, 1'b0);
    step("bne_z0",  32'h00001063, 1'b0, 1'b0, 12'b0_0_01_00_001_000, 1'b0);
    step("bge_n1",  32'h00005063, 1'b0, 1'b1, 12'b0_0_00_00_001_000, 1'b0);
    step("bge_n0",  32'h00005063, 1'b0, 1'b0, 12'b0_0_01_00_001_000, 1'b0);
    step("beq_z1",  32'h00000063, 1'b1, 1'b0, 12'b0_0_01_00_001_000, 1'b0);
    step("blt_n1",  32'h00004063, 1'b0, 1'b1, 12'b0_0_01_00_001_000, 1'b0);
    step("br_f3_2", 32'h00002063, 1'b1, 1'b1, 12'b0_0_00_00_001_000, 1'b0);
    step("jal",     32'h0000006F, 1'b0, 1'b0, 12'b1_0_01_00_000_100, 1'b0);
    step("jalr",    32'h00000067, 1'b0, 1'b0, 12'b1_1_10_00_000_100, 1'b0);
    step("lui",     32'h00000037, 1'b0, 1'b0, 12'b1_1_00_00_110_000, 1'b0);
    step("auipc",   32'h00000017, 1'b0, 1'b0, 12'b1_0_00_00_000_101, 1'b0);
    step("ecall",   32'h00000073, 1'b0, 1'b0, 12'b0_0_00_00_000_000, 1'b0);
    step("unknown", 32'h0000007F, 1'b0, 1'b0, 12'b0_0_00_00_000_000, 1'b0);

    // Non-EBREAK SYSTEM word across an edge must not halt.
    @(posedge clk); #1;
    step("ecall_edge", 32'h00000073, 1'b0, 1'b0, 12'b0_0_00_00_000_000, 1'b0);

    @(negedge clk);
    step("ebreak",  32'h00100073, 1'b0, 1'b0, 12'b0_0_11_00_000_000, 1'b0);
    @(posedge clk); #1;
    step("halt_set", 32'h00100073, 1'b0, 1'b0, 12'b0_0_11_00_000_000, 1'b1);
    @(negedge clk);
    step("halt_add", 32'h00000033, 1'b0, 1'b0, 12'b0_0_11_00_000_000, 1'b1);
    step("halt_sw",  32'h00002023, 1'b0, 1'b0, 12'b0_1_11_00_000_000, 1'b1);
    step("halt_br",  32'h00000063, 1'b1, 1'b0, 12'b0_0_11_00_001_000, 1'b1);
    step("halt_lui", 32'h00000037, 1'b0, 1'b0, 12'b0_1_11_00_110_000, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    step("halt_sticky", 32'h00000033, 1'b0, 1'b0, 12'b0_0_11_00_000_000, 1'b1);

    // Mid-cycle reset pulse clears halt without a clock edge.
    @(posedge clk); #2;
    reset = 1'b1;
    step("rst_mid",   32'h00000033, 1'b0, 1'b0, 12'b0_0_00_00_000_000, 1'b0);
    reset = 1'b0;
    step("add_after", 32'h00000033, 1'b0, 1'b0, 12'b1_0_00_00_000_000, 1'b0);
    @(posedge clk); #1;
    step("add_edge",  32'h00000033, 1'b0, 1'b0, 12'b1_0_00_00_000_000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
